// File: rtl/switch_send_queue.sv
// Per-core egress FIFO between a compute core and one Switch send port.
// Entries are presented in strict FIFO order and held until send_ok.
module switch_send_queue #(
    parameter int WIDTH          = 16,
    parameter int CORE_SIZE      = 8,
    parameter int DEPTH          = 4,
    parameter int CORE_ADDR_SIZE = $clog2(CORE_SIZE),
    parameter int CNT_SIZE       = $clog2(DEPTH) + 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      push_valid,
    input  logic [CORE_ADDR_SIZE-1:0] push_core_idx,
    input  logic [WIDTH*32-1:0]       push_data,
    output logic                      push_ready,
    output logic                      send_ready,
    output logic [CORE_ADDR_SIZE-1:0] send_core_idx,
    output logic [WIDTH*32-1:0]       send_data,
    input  logic                      send_ok,
    output logic [CNT_SIZE-1:0]       count,
    output logic                      idle,
    output logic                      proto_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int DW    = WIDTH * 32;

    logic [CORE_ADDR_SIZE-1:0] idx_mem_q  [DEPTH];
    logic [DW-1:0]             data_mem_q [DEPTH];

    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CNT_SIZE-1:0] count_q, count_d;
    logic                proto_err_q, proto_err_d;

    logic full;
    logic empty;
    logic push_fire;
    logic pop_fire;

    always_comb begin
        full        = (count_q == CNT_SIZE'(DEPTH));
        empty       = (count_q == '0);
        push_fire   = push_valid && !full;
        pop_fire    = send_ok && !empty;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        proto_err_d = proto_err_q;

        if (push_fire) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_fire) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        unique case ({push_fire, pop_fire})
            2'b10:   count_d = count_q + CNT_SIZE'(1);
            2'b01:   count_d = count_q - CNT_SIZE'(1);
            default: count_d = count_q;
        endcase

        // Acknowledge with nothing on offer is a Switch-side protocol bug
        if (send_ok && empty) begin
            proto_err_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            proto_err_q <= 1'b0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            proto_err_q <= proto_err_d;
        end
    end

    // Storage is never cleared; validity is tracked by count alone
    always_ff @(posedge clock) begin
        if (!reset && push_fire) begin
            idx_mem_q[wr_ptr_q]  <= push_core_idx;
            data_mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign push_ready    = !full;
    assign send_ready    = !empty;
    assign send_core_idx = idx_mem_q[rd_ptr_q];
    assign send_data     = data_mem_q[rd_ptr_q];
    assign count         = count_q;
    assign idle          = empty && !push_valid;
    assign proto_err     = proto_err_q;

endmodule

// File: tb/tb_switch_send_queue.sv
// Scoreboard bench for switch_send_queue: directed scenarios then random traffic.
// A queue-level model predicts occupancy; a negedge monitor checks heads and flags.
module tb_switch_send_queue;

    localparam int WIDTH          = 16;
    localparam int CORE_SIZE      = 8;
    localparam int DEPTH          = 4;
    localparam int CORE_ADDR_SIZE = $clog2(CORE_SIZE);
    localparam int CNT_SIZE       = $clog2(DEPTH) + 1;
    localparam int DW             = WIDTH * 32;

    typedef struct {
        logic [CORE_ADDR_SIZE-1:0] idx;
        logic [DW-1:0]             data;
    } entry_t;

    logic                      clock = 1'b0;
    logic                      reset = 1'b1;
    logic                      push_valid = 1'b0;
    logic [CORE_ADDR_SIZE-1:0] push_core_idx = '0;
    logic [DW-1:0]             push_data = '0;
    logic                      push_ready;
    logic                      send_ready;
    logic [CORE_ADDR_SIZE-1:0] send_core_idx;
    logic [DW-1:0]             send_data;
    logic                      send_ok = 1'b0;
    logic [CNT_SIZE-1:0]       count;
    logic                      idle;
    logic                      proto_err;

    switch_send_queue #(
        .WIDTH(WIDTH), .CORE_SIZE(CORE_SIZE), .DEPTH(DEPTH)
    ) dut (
        .clock(clock), .reset(reset),
        .push_valid(push_valid), .push_core_idx(push_core_idx),
        .push_data(push_data), .push_ready(push_ready),
        .send_ready(send_ready), .send_core_idx(send_core_idx),
        .send_data(send_data), .send_ok(send_ok),
        .count(count), .idle(idle), .proto_err(proto_err)
    );

    always #5 clock = ~clock;

    entry_t mq[$];
    entry_t sb[$];
    logic   m_perr = 1'b0;
    bit     started = 1'b0;
    int     errors = 0;
    int     checks = 0;

    task automatic chk(input string nm, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model advance at the active edge, from the inputs the DUT samples
    task automatic step();
        entry_t e;
        bit acc;
        bit pop;
        @(posedge clock);
        if (reset) begin
            mq.delete();
            sb.delete();
            m_perr = 1'b0;
        end else begin
            pop = send_ok && (mq.size() > 0);
            acc = push_valid && (mq.size() < DEPTH);
            if (send_ok && mq.size() == 0) m_perr = 1'b1;
            if (pop) void'(mq.pop_front());
            if (acc) begin
                e.idx  = push_core_idx;
                e.data = push_data;
                mq.push_back(e);
                sb.push_back(e);
            end
        end
        #1;
    endtask

    // Offer one entry until the model says it is accepted
    task automatic push_entry(input logic [CORE_ADDR_SIZE-1:0] idx,
                              input logic [DW-1:0] data);
        bit acc;
        int n = 0;
        push_valid    = 1'b1;
        push_core_idx = idx;
        push_data     = data;
        do begin
            acc = (mq.size() < DEPTH) && !reset;
            step();
            n++;
        end while (!acc && n < 100);
        if (!acc) begin
            errors++;
            checks++;
            $display("FAIL push_timeout: got stuck expected accept");
        end
        push_valid = 1'b0;
    endtask

    function automatic logic [DW-1:0] rnd_data();
        logic [DW-1:0] d;
        for (int i = 0; i < WIDTH; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    function automatic logic [DW-1:0] lane0(input logic [31:0] v);
        logic [DW-1:0] d = '0;
        d[31:0] = v;
        return d;
    endfunction

    always @(negedge clock) begin
        if (started) begin
            chk("count", DW'(count), DW'(mq.size()));
            chk("push_ready", DW'(push_ready), DW'(mq.size() < DEPTH));
            chk("send_ready", DW'(send_ready), DW'(mq.size() != 0));
            chk("idle", DW'(idle), DW'(mq.size() == 0 && !push_valid));
            chk("proto_err", DW'(proto_err), DW'(m_perr));
            if (send_ready === 1'b1) begin
                if (sb.size() == 0) begin
                    errors++;
                    checks++;
                    $display("FAIL head_unexpected: got idx %0d expected none",
                             send_core_idx);
                end else begin
                    chk("head_idx", DW'(send_core_idx), DW'(sb[0].idx));
                    chk("head_data", send_data, sb[0].data);
                    if (send_ok) void'(sb.pop_front());
                end
            end
        end
    end

    logic [31:0] fl [5] = '{32'h3F800000, 32'h40000000, 32'h40400000,
                            32'h40800000, 32'h40A00000};

    initial begin
        reset = 1'b1;
        step();
        started = 1'b1;
        step();
        reset = 1'b0;

        // Single transfer
        push_entry(3'd3, lane0(32'h3F800000));
        step();
        send_ok = 1'b1;
        step();
        send_ok = 1'b0;
        step();

        // Fill to full, hold the fifth, pop once to admit it
        for (int i = 0; i < 4; i++) push_entry(CORE_ADDR_SIZE'(i), lane0(fl[i]));
        push_valid    = 1'b1;
        push_core_idx = 3'd4;
        push_data     = lane0(fl[4]);
        step();
        step();
        send_ok = 1'b1;
        step();
        send_ok = 1'b0;
        step();
        push_valid = 1'b0;
        send_ok = 1'b1;
        for (int i = 0; i < 5; i++) step();
        send_ok = 1'b0;
        step();

        // Simultaneous push/pop from count 2, wrapping pointers
        push_entry(3'd1, rnd_data());
        push_entry(3'd2, rnd_data());
        send_ok = 1'b1;
        for (int i = 0; i < 6; i++) begin
            push_valid    = 1'b1;
            push_core_idx = CORE_ADDR_SIZE'(i);
            push_data     = rnd_data();
            step();
        end
        push_valid = 1'b0;
        step();
        step();
        send_ok = 1'b0;
        step();

        // Head stability with three entries, then back-to-back drain
        for (int i = 0; i < 3; i++) push_entry(CORE_ADDR_SIZE'(5 + i), rnd_data());
        for (int i = 0; i < 20; i++) step();
        send_ok = 1'b1;
        for (int i = 0; i < 3; i++) step();
        send_ok = 1'b0;
        step();

        // Protocol error on empty, sticky across traffic
        send_ok = 1'b1;
        step();
        send_ok = 1'b0;
        step();
        push_entry(3'd6, rnd_data());
        send_ok = 1'b1;
        step();
        send_ok = 1'b0;
        step();

        // Reset mid-operation with coincident push and send_ok
        for (int i = 0; i < 3; i++) push_entry(CORE_ADDR_SIZE'(i), rnd_data());
        reset         = 1'b1;
        push_valid    = 1'b1;
        send_ok       = 1'b1;
        push_data     = rnd_data();
        step();
        reset      = 1'b0;
        push_valid = 1'b0;
        send_ok    = 1'b0;
        for (int i = 0; i < 3; i++) step();

        // Random traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            reset         = ($urandom_range(0, 79) == 0);
            push_valid    = ($urandom_range(0, 99) < 55);
            push_core_idx = CORE_ADDR_SIZE'($urandom_range(0, CORE_SIZE - 1));
            push_data     = rnd_data();
            send_ok       = ($urandom_range(0, 99) < 50);
            step();
        end
        reset      = 1'b0;
        push_valid = 1'b0;
        send_ok    = 1'b1;
        for (int i = 0; i < DEPTH + 2; i++) step();
        send_ok = 1'b0;
        step();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/switch_send_queue.md
Name: switch_send_queue

Overview:
- Per-core egress buffer between a compute core (MatCore/VecCore) and one send port of the Switch.
- Decouples the core from switch back-pressure: the core enqueues (destination index, vector) pairs, and the queue presents them to the Switch in FIFO order.
- Each entry is held stable until the Switch acknowledges it with send_ok.
- One instance per switch port in multi-core tops.

Parameters:
- WIDTH, 16, vector lanes per transfer (matches Switch WIDTH).
- CORE_SIZE, 8, number of switch ports.
- DEPTH, 4, queue entries; power of two, >= 2.
- CORE_ADDR_SIZE, $clog2(CORE_SIZE), destination index width.
- CNT_SIZE, $clog2(DEPTH)+1, occupancy counter width.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- push_valid  in  1  core offers an entry this cycle.
- push_core_idx  in  CORE_ADDR_SIZE  destination port of the offered entry.
- push_data  in  WIDTH*32  offered vector. Lane i is bits [32i+31:32i], IEEE-754 single bit pattern.
- push_ready  out  1  queue can accept an entry this cycle.
- send_ready  out  1  head entry is valid (to Switch send_ready).
- send_core_idx  out  CORE_ADDR_SIZE  head destination (to Switch send_core_idx).
- send_data  out  WIDTH*32  head vector (to Switch send_data).
- send_ok  in  1  Switch accepted the head this cycle.
- count  out  CNT_SIZE  current occupancy, 0..DEPTH.
- idle  out  1  queue empty and no push this cycle.
- proto_err  out  1  sticky: send_ok seen while send_ready low.

Behaviour:
- Storage: DEPTH-entry circular buffer plus rd_ptr/wr_ptr of $clog2(DEPTH) bits each. Pointers wrap modulo DEPTH. count is held explicitly; full = (count==DEPTH), empty = (count==0).
- Reset (synchronous, posedge with reset=1):
  - rd_ptr=0, wr_ptr=0, count=0, proto_err=0.
  - Outputs: push_ready=1, send_ready=0, count=0, idle=1.
  - send_core_idx and send_data are don't-care while send_ready=0. Storage contents are not cleared.
  - Reset mid-operation discards all queued entries. A push or send_ok coincident with reset is ignored.
- push_ready = !full, combinational from count. It is independent of send_ok: a full queue does not accept a push in the same cycle it pops.
- Push occurs when push_valid && push_ready: entry written at wr_ptr, wr_ptr+1.
- send_ready = !empty. send_core_idx/send_data = storage[rd_ptr], driven combinationally from registered state, so they are stable while the head is unchanged.
- Pop occurs when send_ok && send_ready: rd_ptr+1. The next entry appears the following cycle, so back-to-back pops are possible at 1 entry/cycle.
- count next = count + push - pop. Simultaneous push and pop leaves count unchanged; that is legal whenever 0 < count < DEPTH.
- No fall-through: an entry pushed into an empty queue becomes visible on send_ready the next cycle (latency 1). Push and pop cannot coincide when empty.
- send_ok while send_ready=0:
  - No pointer or count change.
  - proto_err set on the next edge and held until reset.
- Ordering: strict FIFO across all destinations. There is no per-destination reordering, so head-of-line blocking is accepted.
- idle = empty && !push_valid.
- Push while full (push_valid=1, push_ready=0): no state change. The core must hold the entry until push_ready.
- Data is opaque. No arithmetic is performed on lanes, and bits are passed through exactly.

Test Plan:
- Reset and single transfer: reset for 2 cycles, then push idx=3 with lane0=0x3F800000 (1.0) and other lanes 0.
  - Next cycle: send_ready=1, send_core_idx=3, lane0=0x3F800000, count=1.
  - Assert send_ok for 1 cycle, then send_ready=0, count=0, idle=1.
- Fill and back-pressure: with send_ok=0, push 5 entries (idx 0..4), lane0 = 1.0, 2.0, 3.0, 4.0, 5.0.
  - After 4 pushes: push_ready=0, count=4.
  - 5th is held. Pop once: push_ready=1, and the 5th (idx 4) is accepted the next cycle.
  - Subsequent heads appear in order 1, 2, 3, 4.
- Simultaneous push/pop: from count=2, drive push_valid and send_ok together for 6 cycles.
  - count stays 2 throughout.
  - Heads observed in push order, with pointers wrapping past index 3 without loss.
- Head stability: hold send_ok=0 for 20 cycles with 3 entries queued.
  - send_core_idx and send_data unchanged every cycle.
  - Release with send_ok held high: 3 pops on 3 consecutive cycles.
- Protocol error: with the queue empty, pulse send_ok.
  - proto_err=1 from the next cycle onward; count stays 0.
  - proto_err remains 1 after further traffic until reset, which clears it.
- Reset mid-operation: with count=3, assert reset together with push_valid and send_ok.
  - Next cycle: count=0, send_ready=0, push_ready=1.
  - None of the old entries is ever presented again.
